arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels, legal 2..16.
REQ-002 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-003 SHALL have parameter MODE, default 0; 0 = fixed select via sel, 1 = round-robin arbitration.
REQ-004 SHALL derive local SELW = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port sel  input  SELW  channel select, used only when MODE=0.
REQ-008 SHALL have port in_valid  input  NUM_CH  per-channel data valid.
REQ-009 SHALL have port in_ready  output  NUM_CH  per-channel accept.
REQ-010 SHALL have port in_data  input  NUM_CH*WIDTH  flattened; channel i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid  output  1  output register holds a word.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-014 SHALL have port out_ch  output  SELW  source channel index of out_data.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready (combinational).
REQ-016 SHALL, in MODE=0, grant channel sel when sel < NUM_CH and in_valid[sel]=1; sel >= NUM_CH grants nothing.
REQ-017 SHALL, in MODE=1, grant the first valid channel searching from (last+1) mod NUM_CH upward with wrap-around, where last = channel of previous transfer.
REQ-018 SHALL drive in_ready[i]=1 only for the granted channel i and only when load_en=1; at most one in_ready bit high per cycle.
REQ-019 SHALL complete an input transfer when in_valid[i] && in_ready[i]; on that edge load out_data, out_ch=i, out_valid=1.
REQ-020 SHALL give exactly 1-cycle latency from input transfer to out_valid.
REQ-021 SHALL clear out_valid when out_ready=1 and no input transfer occurs that cycle.
REQ-022 SHALL, on simultaneous output drain and new input transfer, load the new word with out_valid staying 1 (full throughput, one word per cycle).
REQ-023 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0.
REQ-024 SHALL update last only on an input transfer; no transfer leaves last unchanged.
REQ-025 SHALL never grant a channel whose in_valid=0.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set out_valid=0, out_data=0, out_ch=0, last=NUM_CH-1 (so channel 0 has first priority).
REQ-027 SHALL force in_ready=0 while rst=1.
REQ-028 SHALL discard any held output word on reset mid-operation; no transfer completes on a reset cycle.

Configuration
REQ-029 SHALL support macro ARB_MUX_LOCK_EN; when defined, adds input in_lock [NUM_CH-1:0].
REQ-030 SHALL, with ARB_MUX_LOCK_EN, after a transfer with in_lock[i]=1 keep grant on channel i (both modes, ignoring sel) until a transfer from i with in_lock[i]=0; lock state cleared by reset.
REQ-031 SHALL, without ARB_MUX_LOCK_EN, have no in_lock port and no lock state.

Structure
REQ-032 SHALL place MODE encodings (MODE_FIXED=0, MODE_RR=1) and the SELW clog2 function in shared package arb_mux_pkg.
REQ-033 SHALL implement grant logic in sub-module rr_arbiter (request vector, last pointer in; one-hot grant, index out).

Verification
REQ-034 SHALL test reset: assert rst mid-transfer with out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=0.
REQ-035 SHALL test MODE=0, NUM_CH=4: sel=2, in_valid=4'b1111, in_data ch2=0xA5A5_0002, out_ready=1 -> in_ready=4'b0100, next cycle out_data=0xA5A5_0002, out_ch=2; sel=5 on NUM_CH=4 -> in_ready=0.
REQ-036 SHALL test MODE=1 fairness: all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 SHALL test backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data unchanged, in_ready=0; release -> new word the following cycle.
REQ-038 SHALL test sparse wrap-around: MODE=1, only ch3 and ch0 valid, last=3 -> grant ch0, then ch3, then ch0.
REQ-039 SHALL test ARB_MUX_LOCK_EN: ch1 sends 3 words with in_lock=1,1,0 while ch0,ch2 valid -> out_ch=1,1,1 then 2.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux slice: mode encodings and the
// select-width helper used to size channel index ports.
// The optional channel lock feature is enabled with ARB_MUX_LOCK_EN.
package arb_mux_pkg;

    // Operating modes for the MODE parameter of arb_mux.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Number of bits needed to index n channels, never less than one bit.
    function automatic int calc_selw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant finder shared by both arb_mux modes: scans the request vector
// starting one past the last served channel and wrapping around, and
// returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SELW   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SELW-1:0]   last,
    output logic [NUM_CH-1:0] grant,
    output logic [SELW-1:0]   idx,
    output logic              found
);

    int cand;

    // Priority scan from last+1 upward with wrap; the first hit wins and
    // later hits are ignored, so grant is at most one-hot.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(last) + k) % NUM_CH;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = SELW'(cand);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: selects one of NUM_CH valid/ready input channels, either the
// channel named by sel (MODE_FIXED) or by round-robin (MODE_RR), and
// registers the chosen word into a single-entry output stage that can
// accept a new word on the same cycle it is drained.
// Define ARB_MUX_LOCK_EN to add the in_lock port, which pins the grant to
// a channel across several transfers until it sends a word without lock.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int MODE   = MODE_FIXED,
    localparam int SELW  = calc_selw(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SELW-1:0]         sel,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_ch
`ifdef ARB_MUX_LOCK_EN
    ,
    input  logic [NUM_CH-1:0]       in_lock
`endif
);

    logic              load_en;
    logic              xfer;
    logic [SELW-1:0]   last_ch;
    logic [NUM_CH-1:0] req_vec;
    logic [NUM_CH-1:0] grant_vec;
    logic [SELW-1:0]   grant_idx;
    logic              grant_found;
    logic [WIDTH-1:0]  grant_data;

`ifdef ARB_MUX_LOCK_EN
    logic              lock_active;
    logic [SELW-1:0]   lock_ch;
`endif

    // The output register can take a new word when it is empty or being
    // drained this cycle.
    always_comb begin
        load_en = !out_valid || out_ready;
    end

    // Build the request vector the arbiter sees. In fixed mode only the
    // selected channel may request, so the scan simply finds it; an
    // out-of-range sel leaves the vector empty. A held lock overrides
    // both modes and narrows the request to the locked channel.
    always_comb begin
        req_vec = '0;
        if (MODE == MODE_FIXED) begin
            if (int'(sel) < NUM_CH) begin
                req_vec[sel] = in_valid[sel];
            end
        end else begin
            req_vec = in_valid;
        end
`ifdef ARB_MUX_LOCK_EN
        if (lock_active) begin
            req_vec          = '0;
            req_vec[lock_ch] = in_valid[lock_ch];
        end
`endif
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SELW   (SELW)
    ) u_arbiter (
        .req   (req_vec),
        .last  (last_ch),
        .grant (grant_vec),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // Offer ready only to the granted channel, only when the output stage
    // can load, and never during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && grant_found) begin
            in_ready = grant_vec;
        end
    end

    // A transfer happens when the granted channel is also valid, which the
    // grant already guarantees; the AND keeps the handshake explicit.
    always_comb begin
        xfer = |(in_valid & in_ready);
    end

    // Word of the granted channel, picked out of the flattened bus.
    always_comb begin
        grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // Output stage and round-robin pointer. A transfer loads the word and
    // becomes the new last; otherwise a drain empties the stage and the
    // pointer is left alone. Reset discards any held word and points last
    // at the top channel so channel 0 is served first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last_ch   <= SELW'(NUM_CH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            last_ch   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    // Lock tracking: every transfer re-evaluates the lock from the sending
    // channel's in_lock, so a word sent without lock releases the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_ch     <= '0;
        end else if (xfer) begin
            lock_active <= in_lock[grant_idx];
            lock_ch     <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux. Three instances run side by side on
// shared stimulus: fixed-select with 4 channels, round-robin with 4
// channels, and fixed-select with 3 channels (so sel can be out of range).
// A behavioural model predicts every output each cycle; directed phases
// add literal expectations, then a randomized phase runs with occasional
// resets. Lock scenarios run only when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;

`ifdef ARB_MUX_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   sel;
    logic [1:0]   sel3;
    logic [3:0]   in_valid;
    logic [3:0]   in_lock;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]   rdy_fix, rdy_rr;
    logic [2:0]   rdy3;
    logic         ov_fix, ov_rr, ov3;
    logic [31:0]  od_fix, od_rr, od3;
    logic [1:0]   oc_fix, oc_rr, oc3;

    int total = 0;
    int bad   = 0;

    // model state per instance: 0 = fixed/4, 1 = rr/4, 2 = fixed/3
    bit          started = 1'b0;
    bit          m_valid   [3];
    logic [31:0] m_data    [3];
    int          m_ch      [3];
    int          m_last    [3];
    bit          m_lock    [3];
    int          m_lock_ch [3];

    always #5 clk = ~clk;

    arb_mux #(.NUM_CH(4), .WIDTH(32), .MODE(0)) dut_fix (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_ready(rdy_fix),
        .in_data(in_data), .out_valid(ov_fix), .out_ready(out_ready),
        .out_data(od_fix), .out_ch(oc_fix)
`ifdef ARB_MUX_LOCK_EN
        , .in_lock(in_lock)
`endif
    );

    arb_mux #(.NUM_CH(4), .WIDTH(32), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .sel(2'd0), .in_valid(in_valid), .in_ready(rdy_rr),
        .in_data(in_data), .out_valid(ov_rr), .out_ready(out_ready),
        .out_data(od_rr), .out_ch(oc_rr)
`ifdef ARB_MUX_LOCK_EN
        , .in_lock(in_lock)
`endif
    );

    arb_mux #(.NUM_CH(3), .WIDTH(32), .MODE(0)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .in_valid(in_valid[2:0]), .in_ready(rdy3),
        .in_data(in_data[95:0]), .out_valid(ov3), .out_ready(out_ready),
        .out_data(od3), .out_ch(oc3)
`ifdef ARB_MUX_LOCK_EN
        , .in_lock(in_lock[2:0])
`endif
    );

    function automatic int n_of(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int mode_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic logic [3:0] valid_of(input int d);
        return (d == 2) ? {1'b0, in_valid[2:0]} : in_valid;
    endfunction

    function automatic int sel_of(input int d);
        if (d == 0) return int'(sel);
        if (d == 2) return int'(sel3);
        return 0;
    endfunction

    // Channel the instance should grant right now, or -1 for none.
    function automatic int model_grant(input int d);
        logic [3:0] v;
        int         n;
        int         s;
        int         c;
        v = valid_of(d);
        n = n_of(d);
        if (m_lock[d]) return v[m_lock_ch[d]] ? m_lock_ch[d] : -1;
        if (mode_of(d) == 0) begin
            s = sel_of(d);
            return (s < n && v[s]) ? s : -1;
        end
        for (int k = 1; k <= n; k++) begin
            c = (m_last[d] + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input int d);
        int g;
        g = model_grant(d);
        if (rst || (m_valid[d] && !out_ready) || g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one randomized cycle of inputs.
    task automatic apply_stimulus();
        rst       = ($urandom_range(0, 63) == 0);
        in_valid  = 4'($urandom);
        in_lock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        sel       = 2'($urandom);
        sel3      = 2'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        in_data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Advance the model on each rising edge from the inputs seen at it.
    always @(posedge clk) begin
        int g;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_valid[d]   = 1'b0;
                m_data[d]    = 32'h0;
                m_ch[d]      = 0;
                m_last[d]    = n_of(d) - 1;
                m_lock[d]    = 1'b0;
                m_lock_ch[d] = 0;
            end else if (started) begin
                g = model_grant(d);
                if (g >= 0 && (!m_valid[d] || out_ready)) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = in_data[g*32 +: 32];
                    m_ch[d]    = g;
                    m_last[d]  = g;
                    if (LOCK_ON) begin
                        m_lock[d]    = in_lock[g];
                        m_lock_ch[d] = g;
                    end
                end else if (out_ready) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    // Compare every instance against the model mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            check_output("in_ready[0]", {28'h0, rdy_fix}, {28'h0, model_ready(0)});
            check_output("in_ready[1]", {28'h0, rdy_rr}, {28'h0, model_ready(1)});
            check_output("in_ready[2]", {28'h0, 1'b0, rdy3}, {28'h0, model_ready(2)});
            check_output("out_valid[0]", {31'h0, ov_fix}, {31'h0, m_valid[0]});
            check_output("out_valid[1]", {31'h0, ov_rr}, {31'h0, m_valid[1]});
            check_output("out_valid[2]", {31'h0, ov3}, {31'h0, m_valid[2]});
            check_output("out_data[0]", od_fix, m_data[0]);
            check_output("out_data[1]", od_rr, m_data[1]);
            check_output("out_data[2]", od3, m_data[2]);
            check_output("out_ch[0]", {30'h0, oc_fix}, 32'(m_ch[0]));
            check_output("out_ch[1]", {30'h0, oc_rr}, 32'(m_ch[1]));
            check_output("out_ch[2]", {30'h0, oc3}, 32'(m_ch[2]));
        end
    end

    initial begin
        rst       = 1'b1;
        sel       = 2'd0;
        sel3      = 2'd0;
        in_valid  = 4'b0000;
        in_lock   = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // fixed select of channel 2, round-robin starts at channel 0
        rst       = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        #1;
        check_output("fix_sel2_ready", {28'h0, rdy_fix}, 32'h4);
        check_output("rr_first_ready", {28'h0, rdy_rr}, 32'h1);
        tick();
        check_output("fix_sel2_data", od_fix, 32'hA5A5_0002);
        check_output("fix_sel2_ch", {30'h0, oc_fix}, 32'd2);
        check_output("rr_seq0", {30'h0, oc_rr}, 32'd0);
        tick();
        check_output("rr_seq1", {30'h0, oc_rr}, 32'd1);
        tick();
        check_output("rr_seq2", {30'h0, oc_rr}, 32'd2);
        tick();
        check_output("rr_seq3", {30'h0, oc_rr}, 32'd3);
        tick();
        check_output("rr_seq4", {30'h0, oc_rr}, 32'd0);

        // backpressure for three cycles, then release
        out_ready = 1'b0;
        #1;
        check_output("bp_ready_low", {28'h0, rdy_rr}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("bp_hold_data", od_rr, 32'hA5A5_0000);
            check_output("bp_hold_ready", {28'h0, rdy_rr}, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check_output("bp_release_ready", {28'h0, rdy_rr}, 32'h2);
        tick();
        check_output("bp_release_data", od_rr, 32'hA5A5_0001);

        // out-of-range select and a select on an idle channel
        sel3     = 2'd3;
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        check_output("sel_oob_ready", {29'h0, rdy3}, 32'h0);
        check_output("sel_idle_ready", {28'h0, rdy_fix}, 32'h0);

        // reset while holding a word
        in_valid = 4'b1111;
        rst      = 1'b1;
        #1;
        check_output("rst_ready_forced", {28'h0, rdy_rr}, 32'h0);
        tick();
        check_output("rst_valid", {31'h0, ov_rr}, 32'h0);
        check_output("rst_data", od_rr, 32'h0);
        check_output("rst_ready", {28'h0, rdy_fix}, 32'h0);

        // sparse wrap-around between channels 3 and 0
        rst      = 1'b0;
        in_valid = 4'b1001;
        #1;
        check_output("sparse_ready", {28'h0, rdy_rr}, 32'h1);
        tick();
        check_output("sparse_a", {30'h0, oc_rr}, 32'd0);
        tick();
        check_output("sparse_b", {30'h0, oc_rr}, 32'd3);
        tick();
        check_output("sparse_c", {30'h0, oc_rr}, 32'd0);

`ifdef ARB_MUX_LOCK_EN
        // channel 1 holds the grant over two locked words and one unlocked
        in_valid = 4'b0111;
        in_lock  = 4'b0010;
        tick();
        check_output("lock_a", {30'h0, oc_rr}, 32'd1);
        tick();
        check_output("lock_b", {30'h0, oc_rr}, 32'd1);
        in_lock = 4'b0000;
        tick();
        check_output("lock_c", {30'h0, oc_rr}, 32'd1);
        tick();
        check_output("lock_release", {30'h0, oc_rr}, 32'd2);
`endif

        for (int i = 0; i < 3000; i++) begin
            tick();
            apply_stimulus();
        end
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
